// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with a 2-entry skid buffer.
// Optional perf counters enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W   = 64,
  parameter logic [DATA_W-1:0]    RST_DATA = {DATA_W{1'b0}},
  parameter int unsigned          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_ready;
  logic w_in_fire;

  assign w_in_ready = !r_skid_valid;
  assign w_in_fire  = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // skid occupancy wins, then empty main, then drain, then overflow into skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= RST_DATA;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RST_DATA;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= RST_DATA;
      r_skid_valid <= 1'b0;
      r_skid_data  <= RST_DATA;
    end else if (r_skid_valid) begin
      if (out_ready) begin
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (!r_out_valid) begin
      if (w_in_fire) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      if (w_in_fire) begin
        r_out_data <= in_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_data  <= in_data;
      r_skid_valid <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall;

  assign w_stall   = r_out_valid && !out_ready && !flush;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid.
// Perf counter checks compile in when PIPE_STAGE_SKID_PERF_EN is defined.
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int total;
  int bad;

  pipe_stage_skid #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_ir", 64'(in_ready), 64'd1);
    chk("rst_od", out_data, 64'd0);
    tick();
    rst = 1'b0;

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      tick();
      chk("str_ov", 64'(out_valid), 64'd1);
      chk("str_od", out_data, 64'(i));
      chk("str_ir", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("str_end_ov", 64'(out_valid), 64'd0);
    chk("str_end_od", out_data, 64'd8);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    tick();
    chk("bp_a_od", out_data, 64'hA);
    chk("bp_a_ir", 64'(in_ready), 64'd1);
    in_data = 64'hB;
    tick();
    chk("bp_b_od", out_data, 64'hA);
    chk("bp_b_ir", 64'(in_ready), 64'd0);
    in_data = 64'hC;
    tick();
    chk("bp_hold_od", out_data, 64'hA);
    chk("bp_hold_ir", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b", out_data, 64'hB);
    chk("bp_rel_ov", 64'(out_valid), 64'd1);
    chk("bp_rel_ir", 64'(in_ready), 64'd1);
    tick();
    chk("bp_rel_c", out_data, 64'hC);
    chk("bp_rel_c_ov", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_ov", 64'(out_valid), 64'd0);
    chk("bp_drain_od", out_data, 64'hC);

    // flush with main and skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    tick();
    in_data = 64'hB;
    tick();
    chk("fl_pre_ir", 64'(in_ready), 64'd0);
    flush   = 1'b1;
    in_data = 64'hD;
    tick();
    chk("fl_ov", 64'(out_valid), 64'd0);
    chk("fl_ir", 64'(in_ready), 64'd1);
    chk("fl_od", out_data, 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("fl_drop_ov", 64'(out_valid), 64'd0);

    // flush then refill
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 64'hE;
    tick();
    chk("refill_ov", 64'(out_valid), 64'd1);
    chk("refill_od", out_data, 64'hE);
    in_valid = 1'b0;

    // async reset mid-cycle with out_valid=1
    chk("ar_pre_ov", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ov", 64'(out_valid), 64'd0);
    chk("ar_ir", 64'(in_ready), 64'd1);
    chk("ar_od", out_data, 64'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("ar_after_ov", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_SKID_PERF_EN
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("perf_stall5", 64'(stall_cnt), 64'd5);
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    chk("perf_stall", 64'(stall_cnt), 64'd5);
    chk("perf_flush", 64'(flush_cnt), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
